// File: rtl/filter_pkg.sv
// Shared types, constants and helpers for the biquad filter chain.
package filter_pkg;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 14;
  localparam int ACC_W     = 40;
  localparam int NUM_TAPS  = 5;

  typedef logic signed [DATA_W-1:0]        sample_t;
  typedef logic signed [COEF_W-1:0]        coef_t;
  typedef logic signed [ACC_W-1:0]         acc_t;
  typedef logic signed [COEF_W+DATA_W-1:0] prod_t;

  localparam coef_t   COEF_UNITY = coef_t'(16384);
  localparam sample_t SAMPLE_MAX = sample_t'(32767);
  localparam sample_t SAMPLE_MIN = sample_t'(-32768);
  localparam acc_t    ACC_HALF   = acc_t'(2 ** (COEF_FRAC - 1));

  // Tap order inside one stage evaluation.
  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    A1 = 3'd3,
    A2 = 3'd4
  } tap_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Direct-form-I history of one stage.
  typedef struct packed {
    sample_t x1;
    sample_t x2;
    sample_t y1;
    sample_t y2;
  } hist_t;

  // Round half up at the Q2.14 binary point, then clamp to the sample range.
  function automatic sample_t round_sat(input acc_t acc);
    acc_t shifted;
    shifted = (acc + ACC_HALF) >>> COEF_FRAC;
    if (shifted > acc_t'(SAMPLE_MAX)) begin
      round_sat = SAMPLE_MAX;
    end else if (shifted < acc_t'(SAMPLE_MIN)) begin
      round_sat = SAMPLE_MIN;
    end else begin
      round_sat = sample_t'(shifted);
    end
  endfunction

endpackage

// File: rtl/biquad_scheduler_if.sv
// Sample stream, coefficient port and status flags of the biquad scheduler.
interface biquad_scheduler_if #(
  parameter int NUM_STAGES = 3
);
  import filter_pkg::*;

  localparam int ADDR_W = $clog2(NUM_TAPS * NUM_STAGES);

  logic                  sample_valid;
  sample_t               sample_in;
  logic                  sample_ready;
  sample_t               sample_out;
  logic                  out_valid;
  logic                  coef_wr_en;
  logic [ADDR_W-1:0]     coef_wr_addr;
  coef_t                 coef_wr_data;
  logic [NUM_STAGES-1:0] stage_bypass;
  logic                  busy;
  logic                  overrun;
  logic                  coef_wr_err;

  modport slave (
    input  sample_valid, sample_in, coef_wr_en, coef_wr_addr, coef_wr_data, stage_bypass,
    output sample_ready, sample_out, out_valid, busy, overrun, coef_wr_err
  );

  modport master (
    output sample_valid, sample_in, coef_wr_en, coef_wr_addr, coef_wr_data, stage_bypass,
    input  sample_ready, sample_out, out_valid, busy, overrun, coef_wr_err
  );

endinterface

// File: rtl/biquad_mac.sv
// Shared multiply-accumulate: registered product, then add/subtract into the
// accumulator. result_o is the rounded, saturated value of the running sum
// including the product currently held, so it is valid the cycle after the
// last tap was issued.
module biquad_mac
  import filter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    mul_en_i,
  input  logic    clear_i,
  input  logic    sub_i,
  input  coef_t   coef_i,
  input  sample_t data_i,
  output sample_t result_o
);

  prod_t prod_q;
  logic  first_q;
  logic  sub_q;
  logic  vld_q;
  acc_t  acc_q;
  acc_t  acc_d;
  acc_t  acc_base;
  acc_t  prod_ext;

  // Product register with its tap flags, then accumulator update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      first_q <= 1'b0;
      sub_q   <= 1'b0;
      vld_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      vld_q <= mul_en_i;
      if (mul_en_i) begin
        prod_q  <= prod_t'(coef_i) * prod_t'(data_i);
        first_q <= clear_i;
        sub_q   <= sub_i;
      end
      if (vld_q) begin
        acc_q <= acc_d;
      end
    end
  end

  // Sign-extend the product; the first tap of a stage starts from zero.
  always_comb begin
    acc_base = first_q ? '0 : acc_q;
    prod_ext = acc_t'(prod_q);
    acc_d    = sub_q ? (acc_base - prod_ext) : (acc_base + prod_ext);
  end

  assign result_o = round_sat(acc_d);

endmodule

// File: rtl/biquad_scheduler.sv
// Time-multiplexes one MAC over NUM_STAGES cascaded direct-form-I biquads.
// Each stage takes five MAC cycles plus one writeback, so latency is fixed
// at 6*NUM_STAGES+1 cycles from acceptance to out_valid.
module biquad_scheduler
  import filter_pkg::*;
#(
  parameter int NUM_STAGES = 3
) (
  input logic                 clk,
  input logic                 reset_n,
  biquad_scheduler_if.slave   bus
);

  localparam int NUM_COEF = NUM_TAPS * NUM_STAGES;
  localparam int ADDR_W   = $clog2(NUM_COEF);
  localparam int STAGE_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  state_e                state_q, state_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  tap_e                  tap_q, tap_d;
  sample_t               x0_q;
  logic [NUM_STAGES-1:0] bypass_q;
  sample_t               sample_out_q;
  coef_t                 coef_q [NUM_COEF];
  hist_t                 hist_w [NUM_STAGES];

  logic                  accept;
  logic                  mac_en;
  logic                  coef_wr_ok;
  logic [ADDR_W-1:0]     rd_addr;
  hist_t                 cur_hist;
  sample_t               mac_data;
  sample_t               mac_result;
  sample_t               wb_result;

  // Next-state and sequencing control.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    tap_d   = tap_q;
    accept  = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.sample_valid) begin
          accept  = 1'b1;
          state_d = ST_MAC;
          stage_d = '0;
          tap_d   = B0;
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (tap_q == A2) begin
          state_d = ST_WB;
        end else begin
          tap_d = tap_e'(tap_q + 3'd1);
        end
      end
      ST_WB: begin
        tap_d = B0;
        if (stage_q == STAGE_W'(NUM_STAGES - 1)) begin
          state_d = ST_DONE;
        end else begin
          stage_d = stage_q + STAGE_W'(1);
          state_d = ST_MAC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, stage/tap counters, current stage input and output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      stage_q      <= '0;
      tap_q        <= B0;
      x0_q         <= '0;
      bypass_q     <= '0;
      sample_out_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      tap_q   <= tap_d;
      if (accept) begin
        x0_q     <= bus.sample_in;
        bypass_q <= bus.stage_bypass;
      end else if (state_q == ST_WB) begin
        x0_q <= wb_result;
      end
      if ((state_q == ST_WB) && (state_d == ST_DONE)) begin
        sample_out_q <= wb_result;
      end
    end
  end

  // Host writes land only while idle, so a same-cycle sample sees them.
  assign coef_wr_ok = bus.coef_wr_en && (state_q == ST_IDLE) &&
                      (bus.coef_wr_addr < ADDR_W'(NUM_COEF));

  // Coefficient store; reset leaves every stage as a unity pass-through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        coef_q[i] <= ((i % NUM_TAPS) == 0) ? COEF_UNITY : coef_t'(0);
      end
    end else if (coef_wr_ok) begin
      coef_q[bus.coef_wr_addr] <= bus.coef_wr_data;
    end
  end

  // Per-stage history, touched only in that stage's writeback cycle.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    hist_t hist_q;
    logic  wb_hit;

    assign wb_hit = (state_q == ST_WB) && (stage_q == STAGE_W'(gi));

    // Shift history on writeback; a bypassed stage is left cleared.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hist_q <= '0;
      end else if (wb_hit) begin
        if (bypass_q[gi]) begin
          hist_q <= '0;
        end else begin
          hist_q.x2 <= hist_q.x1;
          hist_q.x1 <= x0_q;
          hist_q.y2 <= hist_q.y1;
          hist_q.y1 <= mac_result;
        end
      end
    end

    assign hist_w[gi] = hist_q;
  end

  assign rd_addr = ADDR_W'(stage_q) * ADDR_W'(NUM_TAPS) + ADDR_W'(tap_q);

  // Data operand for the current tap.
  always_comb begin
    cur_hist = hist_w[stage_q];
    mac_data = x0_q;
    case (tap_q)
      B0:      mac_data = x0_q;
      B1:      mac_data = cur_hist.x1;
      B2:      mac_data = cur_hist.x2;
      A1:      mac_data = cur_hist.y1;
      A2:      mac_data = cur_hist.y2;
      default: mac_data = x0_q;
    endcase
  end

  biquad_mac u_mac (
    .clk      (clk),
    .rst_n    (reset_n),
    .mul_en_i (mac_en),
    .clear_i  (tap_q == B0),
    .sub_i    ((tap_q == A1) || (tap_q == A2)),
    .coef_i   (coef_q[rd_addr]),
    .data_i   (mac_data),
    .result_o (mac_result)
  );

  assign wb_result = bypass_q[stage_q] ? x0_q : mac_result;

  assign bus.sample_ready = (state_q == ST_IDLE);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.out_valid    = (state_q == ST_DONE);
  assign bus.sample_out   = sample_out_q;
  assign bus.overrun      = bus.sample_valid && (state_q != ST_IDLE);
  assign bus.coef_wr_err  = bus.coef_wr_en && !coef_wr_ok;

endmodule

// File: tb/tb_biquad_scheduler.sv
// Directed bench for biquad_scheduler with hand-computed expected outputs.
module tb_biquad_scheduler;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  int   dout;
  int   lat;
  int   saw_valid;

  biquad_scheduler_if #(.NUM_STAGES(3)) bus ();

  biquad_scheduler #(.NUM_STAGES(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = 4'(addr);
    bus.coef_wr_data = 16'(val);
    @(negedge clk);
    bus.coef_wr_en   = 1'b0;
  endtask

  // Send one sample and wait (bounded) for out_valid; latency counted in cycles.
  task automatic run_sample(input int din, input logic [2:0] byp,
                            output int res, output int latency);
    @(negedge clk);
    bus.sample_in    = 16'(din);
    bus.stage_bypass = byp;
    bus.sample_valid = 1'b1;
    res     = 0;
    latency = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      #1;
      if (bus.out_valid) begin
        latency = c;
        res     = int'(bus.sample_out);
        break;
      end
    end
  endtask

  task automatic chk_sample(input string tag, input int din, input logic [2:0] byp,
                            input int exp);
    int r;
    int l;
    run_sample(din, byp, r, l);
    check(tag, r, exp);
    check({tag, "_lat"}, l, 19);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.coef_wr_en   = 1'b0;
    bus.coef_wr_addr = '0;
    bus.coef_wr_data = '0;
    bus.stage_bypass = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;

    // Reset state
    check("rst_sample_out", int'(bus.sample_out), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ready", int'(bus.sample_ready), 1);
    check("rst_overrun", int'(bus.overrun), 0);
    check("rst_wr_err", int'(bus.coef_wr_err), 0);

    // Identity coefficients after reset
    chk_sample("ident_pos", 12345, 3'b000, 12345);
    chk_sample("ident_min", -32768, 3'b000, -32768);

    // Gain of one half on stage 0
    write_coef(0, 8192);
    chk_sample("gain_20000", 20000, 3'b000, 10000);
    chk_sample("gain_neg3", -3, 3'b000, -1);

    // First-order recursion y = x + 0.5*y1
    write_coef(0, 16384);
    write_coef(3, -8192);
    chk_sample("flush0", 0, 3'b111, 0);
    chk_sample("rec_0", 16384, 3'b000, 16384);
    chk_sample("rec_1", 0, 3'b000, 8192);
    chk_sample("rec_2", 0, 3'b000, 4096);
    chk_sample("rec_3", 0, 3'b000, 2048);

    // Saturation with b0 just under 2.0
    write_coef(3, 0);
    write_coef(0, 32767);
    chk_sample("sat_pos", 32767, 3'b000, 32767);
    chk_sample("sat_neg", -32768, 3'b000, -32768);

    // Bypass passes through and clears stage history
    write_coef(0, 16384);
    write_coef(3, -8192);
    chk_sample("flush1", 0, 3'b111, 0);
    chk_sample("byp_pre0", 16384, 3'b000, 16384);
    chk_sample("byp_pre1", 0, 3'b000, 8192);
    chk_sample("byp_on", 1000, 3'b001, 1000);
    chk_sample("byp_off0", 16384, 3'b000, 16384);
    chk_sample("byp_off1", 0, 3'b000, 8192);

    // Overrun and busy coefficient write during one computation
    write_coef(3, 0);
    @(negedge clk);
    bus.sample_in    = 16'(500);
    bus.stage_bypass = '0;
    bus.sample_valid = 1'b1;
    dout = 0;
    lat  = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.sample_valid = (c == 5);
      bus.sample_in    = (c == 5) ? 16'(777) : 16'(500);
      bus.coef_wr_en   = (c == 8);
      bus.coef_wr_addr = 4'd0;
      bus.coef_wr_data = 16'(8192);
      #1;
      if (c == 5) check("overrun_pulse", int'(bus.overrun), 1);
      if (c == 6) check("overrun_clear", int'(bus.overrun), 0);
      if (c == 8) check("wr_err_busy", int'(bus.coef_wr_err), 1);
      if (c == 18) check("out_held", int'(bus.sample_out), 8192);
      if (bus.out_valid) begin
        lat  = c;
        dout = int'(bus.sample_out);
        break;
      end
    end
    bus.sample_valid = 1'b0;
    bus.coef_wr_en   = 1'b0;
    check("overrun_result", dout, 500);
    check("overrun_lat", lat, 19);
    chk_sample("coef_unchanged", 600, 3'b000, 600);

    // Out-of-range address rejected, in-range idle write accepted
    @(negedge clk);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = 4'd15;
    bus.coef_wr_data = 16'(0);
    #1;
    check("wr_err_range", int'(bus.coef_wr_err), 1);
    @(negedge clk);
    bus.coef_wr_addr = 4'd3;
    #1;
    check("wr_ok_idle", int'(bus.coef_wr_err), 0);
    @(negedge clk);
    bus.coef_wr_en = 1'b0;

    // Reset mid-computation
    write_coef(0, 8192);
    write_coef(3, -8192);
    chk_sample("flush2", 0, 3'b111, 0);
    chk_sample("pre_rst", 16384, 3'b000, 8192);
    @(negedge clk);
    bus.sample_in    = 16'(16384);
    bus.sample_valid = 1'b1;
    saw_valid = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      if (c == 10) reset_n = 1'b0;
      if (c == 13) reset_n = 1'b1;
      #1;
      if (bus.out_valid) saw_valid = 1;
      if (c == 11) begin
        check("midrst_out", int'(bus.sample_out), 0);
        check("midrst_busy", int'(bus.busy), 0);
      end
    end
    check("midrst_no_valid", saw_valid, 0);
    check("midrst_ready", int'(bus.sample_ready), 1);
    write_coef(3, -8192);
    chk_sample("midrst_hist", 0, 3'b000, 0);
    write_coef(3, 0);
    chk_sample("midrst_coef", 12345, 3'b000, 12345);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/biquad_scheduler.md
Name: biquad_scheduler

Overview:
- Time-multiplexes one shared 16x16 multiply-accumulate unit across NUM_STAGES cascaded direct-form-I biquad stages of the channel-strip filter chain (lowpass, highpass, shelf).
- Accepts one 16-bit signed sample per fs = 48 kHz period from the audio interface, sequences all stages, and emits the filtered sample.
- Owns the coefficient RAM and the per-stage history registers; a host writes coefficients between samples.

Parameters:
- NUM_STAGES, 3: cascaded biquad stages, evaluated in order 0..NUM_STAGES-1.
- DATA_W, 16: sample width, signed two's complement.
- COEF_W, 16: coefficient width, signed Q2.14.
- COEF_FRAC, 14: coefficient fractional bits.
- ACC_W, 40: accumulator width, signed.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_valid  in  1  input sample strobe
- sample_in  in  DATA_W  signed input sample
- sample_ready  out  1  high when idle and able to accept a sample
- sample_out  out  DATA_W  signed filtered sample, held between updates
- out_valid  out  1  one-cycle pulse when sample_out updates
- coef_wr_en  in  1  coefficient write strobe
- coef_wr_addr  in  $clog2(5*NUM_STAGES)  address = stage*5 + tap; taps are b0, b1, b2, a1, a2
- coef_wr_data  in  COEF_W  coefficient value, Q2.14
- stage_bypass  in  NUM_STAGES  per-stage bypass, sampled at sample accept
- busy  out  1  high while a sample is in flight
- overrun  out  1  one-cycle pulse when a sample is dropped
- coef_wr_err  out  1  one-cycle pulse when a coefficient write is rejected

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - FSM goes to IDLE; all history registers (x1, x2, y1, y2 per stage) clear to 0.
  - Coefficients load identity: b0 = 16384, all others 0.
  - sample_out = 0; out_valid, busy, overrun, coef_wr_err = 0; sample_ready = 1 after release.
- FSM states: IDLE -> MAC -> WB -> (MAC of next stage | DONE) -> IDLE.
  - IDLE: sample_ready = 1. On sample_valid, latch sample_in and stage_bypass, clear stage = 0, tap = 0, go to MAC. Acceptance cycle is cycle 0.
  - MAC: one product per cycle, taps in order b0*x0, b1*x1, b2*x2, a1*y1, a2*y2. Each product is sign-extended to ACC_W. b-terms are added and a-terms subtracted: y = b0x0 + b1x1 + b2x2 - a1y1 - a2y2. Accumulator clears at tap 0. After tap 4, go to WB.
  - WB:
    - Result = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, saturated to [-32768, 32767].
    - Update history: x2 <= x1, x1 <= x0, y2 <= y1, y1 <= result.
    - Result becomes x0 of the next stage. If stage < NUM_STAGES-1, increment stage and go to MAC; otherwise go to DONE.
  - DONE: register sample_out, pulse out_valid for one cycle, return to IDLE.
- Timing:
  - Fixed latency: out_valid asserts at cycle 6*NUM_STAGES + 1 after acceptance (19 with defaults).
  - Next sample can be accepted the cycle after out_valid.
  - busy = not IDLE.
- Bypassed stage:
  - Still occupies 6 cycles, so latency stays constant.
  - WB passes x0 through unchanged and clears that stage's history to 0, so re-enabling the stage is transient-free.
- sample_valid while busy: the sample is dropped and overrun pulses that cycle. The in-flight computation is unaffected.
- Coefficient writes:
  - Applied only in IDLE with an in-range address, taking effect on the next sample.
  - Ignored, with a coef_wr_err pulse, when busy or when the address is >= 5*NUM_STAGES.
  - sample_valid and coef_wr_en in the same IDLE cycle: both take effect, and the write applies before the MAC reads it.

Decomposition:
- Shared package filter_pkg holds:
  - types sample_t, coef_t, acc_t;
  - constants NUM_TAPS = 5, COEF_UNITY = 16384, SAMPLE_MAX / SAMPLE_MIN;
  - tap index enum (B0, B1, B2, A1, A2) and FSM state enum.
- One sub-module, biquad_mac: registered multiply plus accumulate/subtract, with the clear, round and saturate stage. The scheduler owns sequencing, history, and the coefficient RAM.

Test Plan:
- Identity after reset: sample_in = 12345 -> out_valid exactly 19 cycles later with sample_out = 12345. Repeat with -32768 -> -32768.
- Gain: write stage0 b0 = 8192, keep identity elsewhere; input 20000 -> output 10000. Input -3 -> output -1 (round half up: -1.5 -> -1).
- Recursion: stage0 b0 = 16384, a1 = -8192; impulse 16384 then zeros on three further samples -> outputs 16384, 8192, 4096, 2048.
- Saturation: stage0 b0 = 32767; input 32767 -> 32767; input -32768 -> -32768; no wrap.
- Bypass:
  - Load the recursion coefficients, run two samples, then set stage_bypass[0] = 1 -> output equals input and latency is still 19.
  - Clear the bypass -> next impulse response starts with zero history.
- Protocol faults:
  - sample_valid at cycle 5 of busy -> overrun pulse, output unchanged.
  - coef_wr_en while busy -> coef_wr_err pulse, coefficient unchanged.
  - reset_n low at cycle 10 -> no out_valid; outputs, history and coefficients return to reset values.
